// File: rtl/oup_ulpi_reg_sequencer.sv
// ULPI link-side register sequencer: runs single PHY register writes/reads
// and captures RX CMD bytes whenever the PHY owns the bus.
module oup_ulpi_reg_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       ulpi_clk_i,
    input  logic       rst_i,
    input  logic [7:0] ins_instruction_i,
    input  logic       ins_exec_i,
    input  logic       ins_reset_i,
    output logic       ins_busy_o,
    output logic       ins_exec_done_o,
    output logic       ins_exec_aborted_o,
    input  logic [7:0] phyreg_addr_i,
    input  logic [7:0] phyreg_data_i,
    output logic [7:0] phyreg_data_o,
    output logic [7:0] rx_cmd_byte_o,
    output logic       rx_cmd_valid_o,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o
);

    localparam logic [7:0] REG_WRITE = 8'h01;
    localparam logic [7:0] REG_READ  = 8'h02;
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, W_CMD, W_DATA, W_STP, R_CMD, R_TURN, R_DATA, RX_TURN, RX, TURN_BACK
    } state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [7:0] addr_q, addr_n, wdata_q, wdata_n;
    logic [7:0] data_q, data_n, phyreg_q, phyreg_n, rx_byte_q, rx_byte_n;
    logic drive_q, drive_n, stp_q, stp_n;
    logic done_q, done_n, aborted_q, aborted_n, rx_valid_q, rx_valid_n;
    logic waiting, timeout, accept;

    assign waiting = (state == W_CMD) || (state == W_DATA) || (state == R_CMD) || (state == R_TURN);
    assign timeout = waiting && (cnt == CNT_LAST);
    assign accept  = ((ins_instruction_i == REG_WRITE) || (ins_instruction_i == REG_READ))
                     && (phyreg_addr_i[7:6] == 2'b00);

    assign ins_busy_o         = (state != IDLE);
    assign ins_exec_done_o    = done_q;
    assign ins_exec_aborted_o = aborted_q;
    assign phyreg_data_o      = phyreg_q;
    assign rx_cmd_byte_o      = rx_byte_q;
    assign rx_cmd_valid_o     = rx_valid_q;
    assign ulpi_data_o        = data_q;
    assign ulpi_stp_o         = stp_q;
    // The PHY always wins the bus: drop our drive the moment dir rises.
    assign ulpi_data_oe_o     = drive_q & ~ulpi_dir_i;

    always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            data_q     <= 8'h00;
            drive_q    <= 1'b0;
            stp_q      <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            phyreg_q   <= 8'h00;
            rx_byte_q  <= 8'h00;
        end else begin
            state      <= state_next;
            cnt        <= (ins_reset_i || !waiting || (state_next != state)) ? '0 : cnt + 1'b1;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            data_q     <= data_n;
            drive_q    <= drive_n;
            stp_q      <= stp_n;
            done_q     <= done_n;
            aborted_q  <= aborted_n;
            rx_valid_q <= rx_valid_n;
            phyreg_q   <= phyreg_n;
            rx_byte_q  <= rx_byte_n;
        end
    end

    // A dir rise beats both nxt progress and the timeout in the wait states.
    always_comb begin
        state_next = state;
        if (ins_reset_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ulpi_dir_i)
                        state_next = RX_TURN;
                    else if (ins_exec_i && accept)
                        state_next = (ins_instruction_i == REG_WRITE) ? W_CMD : R_CMD;
                end
                W_CMD: begin
                    if (ulpi_dir_i)      state_next = RX_TURN;
                    else if (ulpi_nxt_i) state_next = W_DATA;
                    else if (timeout)    state_next = IDLE;
                end
                W_DATA: begin
                    if (ulpi_dir_i)      state_next = RX_TURN;
                    else if (ulpi_nxt_i) state_next = W_STP;
                    else if (timeout)    state_next = IDLE;
                end
                W_STP:  state_next = IDLE;
                R_CMD: begin
                    if (ulpi_dir_i)      state_next = RX_TURN;
                    else if (ulpi_nxt_i) state_next = R_TURN;
                    else if (timeout)    state_next = IDLE;
                end
                R_TURN: begin
                    if (ulpi_dir_i)      state_next = R_DATA;
                    else if (timeout)    state_next = IDLE;
                end
                R_DATA:    state_next = ulpi_dir_i ? TURN_BACK : IDLE;
                RX_TURN:   state_next = RX;
                RX:        state_next = ulpi_dir_i ? RX : TURN_BACK;
                TURN_BACK: state_next = ulpi_dir_i ? RX_TURN : IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Registered outputs are derived from the state being entered next.
    always_comb begin
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        if ((state == IDLE) && ins_exec_i && !ins_reset_i) begin
            addr_n  = phyreg_addr_i;
            wdata_n = phyreg_data_i;
        end

        drive_n = (state_next == W_CMD) || (state_next == W_DATA)
                  || (state_next == W_STP) || (state_next == R_CMD);
        stp_n   = (state_next == W_STP);
        case (state_next)
            W_CMD:   data_n = {2'b10, addr_n[5:0]};
            W_DATA:  data_n = wdata_n;
            R_CMD:   data_n = {2'b11, addr_n[5:0]};
            default: data_n = 8'h00;
        endcase

        done_n = !ins_reset_i && ((state == W_STP) || ((state == R_DATA) && ulpi_dir_i));

        aborted_n = 1'b0;
        if (ins_reset_i) begin
            aborted_n = (state != IDLE);
        end else begin
            case (state)
                IDLE:                        aborted_n = ins_exec_i && (ulpi_dir_i || !accept);
                W_CMD, W_DATA, R_CMD, R_TURN: aborted_n = (state_next == IDLE) || (state_next == RX_TURN);
                R_DATA:                      aborted_n = !ulpi_dir_i;
                default:                     aborted_n = 1'b0;
            endcase
        end

        phyreg_n = phyreg_q;
        if (!ins_reset_i && (state == R_DATA) && ulpi_dir_i)
            phyreg_n = ulpi_data_i;

        rx_byte_n  = rx_byte_q;
        rx_valid_n = 1'b0;
        if (!ins_reset_i && (state == RX) && ulpi_dir_i && !ulpi_nxt_i) begin
            rx_byte_n  = ulpi_data_i;
            rx_valid_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_oup_ulpi_reg_sequencer.sv
// Directed and randomized checks of the ULPI register sequencer against a
// transaction-level model of the bus protocol.
`timescale 1ns/1ps
module tb_oup_ulpi_reg_sequencer;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ins_instruction;
    logic       ins_exec, ins_reset, ins_busy, ins_exec_done, ins_exec_aborted;
    logic [7:0] phyreg_addr, phyreg_data_in, phyreg_data_out, rx_cmd_byte;
    logic       rx_cmd_valid;
    logic [7:0] ulpi_data_in, ulpi_data_out;
    logic       ulpi_data_oe, ulpi_dir, ulpi_nxt, ulpi_stp;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_phyreg = 8'h00;
    logic [7:0] exp_rxbyte = 8'h00;

    always #5 clk = ~clk;

    oup_ulpi_reg_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .ulpi_clk_i         (clk),
        .rst_i              (rst),
        .ins_instruction_i  (ins_instruction),
        .ins_exec_i         (ins_exec),
        .ins_reset_i        (ins_reset),
        .ins_busy_o         (ins_busy),
        .ins_exec_done_o    (ins_exec_done),
        .ins_exec_aborted_o (ins_exec_aborted),
        .phyreg_addr_i      (phyreg_addr),
        .phyreg_data_i      (phyreg_data_in),
        .phyreg_data_o      (phyreg_data_out),
        .rx_cmd_byte_o      (rx_cmd_byte),
        .rx_cmd_valid_o     (rx_cmd_valid),
        .ulpi_data_i        (ulpi_data_in),
        .ulpi_data_o        (ulpi_data_out),
        .ulpi_data_oe_o     (ulpi_data_oe),
        .ulpi_dir_i         (ulpi_dir),
        .ulpi_nxt_i         (ulpi_nxt),
        .ulpi_stp_o         (ulpi_stp)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, expv);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic exec, input logic [7:0] instr, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic dir, input logic nxt,
                                 input logic [7:0] din, input logic ireset);
        ins_exec        = exec;
        ins_instruction = instr;
        phyreg_addr     = addr;
        phyreg_data_in  = wdata;
        ulpi_dir        = dir;
        ulpi_nxt        = nxt;
        ulpi_data_in    = din;
        ins_reset       = ireset;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // The bus byte a link sends to open a register access: 10aaaaaa or 11aaaaaa.
    function automatic logic [7:0] cmdByte(input logic is_read, input logic [7:0] addr);
        return (is_read ? 8'hC0 : 8'h80) + (addr % 8'd64);
    endfunction

    task automatic doWrite(input logic [7:0] addr, input logic [7:0] wdata,
                           input int wc, input int wd, input logic busy_exec);
        logic [7:0] cmd;
        cmd = cmdByte(1'b0, addr);
        applyStimulus(1'b1, 8'h01, addr, wdata, 1'b0, 1'b0, 8'h00, 1'b0);
        checkFlag("wr_idle_oe", ulpi_data_oe, 1'b0);
        tick();
        checkOutput("wr_cmd", ulpi_data_out, cmd);
        checkFlag("wr_busy", ins_busy, 1'b1);
        for (int i = 0; i < wc; i++) begin
            applyStimulus(busy_exec, 8'h02, ~addr, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            checkFlag("wr_cmd_oe", ulpi_data_oe, 1'b1);
            tick();
            checkOutput("wr_cmd_hold", ulpi_data_out, cmd);
            checkFlag("wr_cmd_noabort", ins_exec_aborted, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("wr_data", ulpi_data_out, wdata);
        for (int i = 0; i < wd; i++) begin
            applyIdle();
            checkFlag("wr_data_oe", ulpi_data_oe, 1'b1);
            tick();
            checkOutput("wr_data_hold", ulpi_data_out, wdata);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("wr_stp_data", ulpi_data_out, 8'h00);
        checkFlag("wr_stp", ulpi_stp, 1'b1);
        checkFlag("wr_stp_nodone", ins_exec_done, 1'b0);
        applyIdle();
        checkFlag("wr_stp_oe", ulpi_data_oe, 1'b1);
        tick();
        checkFlag("wr_done", ins_exec_done, 1'b1);
        checkFlag("wr_stp_off", ulpi_stp, 1'b0);
        checkFlag("wr_busy_off", ins_busy, 1'b0);
        applyIdle();
        checkFlag("wr_end_oe", ulpi_data_oe, 1'b0);
        tick();
        checkFlag("wr_done_once", ins_exec_done, 1'b0);
    endtask

    task automatic doRead(input logic [7:0] addr, input logic [7:0] rdata, input int wc, input int wt);
        logic [7:0] cmd;
        cmd = cmdByte(1'b1, addr);
        applyStimulus(1'b1, 8'h02, addr, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("rd_cmd", ulpi_data_out, cmd);
        for (int i = 0; i < wc; i++) begin
            applyIdle();
            checkFlag("rd_cmd_oe", ulpi_data_oe, 1'b1);
            tick();
            checkOutput("rd_cmd_hold", ulpi_data_out, cmd);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < wt; i++) begin
            applyIdle();
            checkFlag("rd_turn_oe", ulpi_data_oe, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0);
        checkFlag("rd_dir_oe", ulpi_data_oe, 1'b0);
        tick();
        checkFlag("rd_turn_nodone", ins_exec_done, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, rdata, 1'b0);
        tick();
        exp_phyreg = rdata;
        checkOutput("rd_phyreg", phyreg_data_out, exp_phyreg);
        checkFlag("rd_done", ins_exec_done, 1'b1);
        checkFlag("rd_turnback_busy", ins_busy, 1'b1);
        applyIdle();
        tick();
        checkFlag("rd_busy_off", ins_busy, 1'b0);
        checkFlag("rd_done_once", ins_exec_done, 1'b0);
    endtask

    // Entered in the turnaround cycle after the PHY took the bus.
    task automatic rxBurst(input logic [7:0] first, input int n);
        logic       f;
        logic [7:0] b;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0);
        tick();
        checkFlag("rx_turn_novalid", rx_cmd_valid, 1'b0);
        checkFlag("rx_turn_noabort", ins_exec_aborted, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, first, 1'b0);
        tick();
        exp_rxbyte = first;
        checkFlag("rx_first_valid", rx_cmd_valid, 1'b1);
        checkOutput("rx_first_byte", rx_cmd_byte, exp_rxbyte);
        for (int i = 0; i < n; i++) begin
            f = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, f, b, 1'b0);
            checkFlag("rx_oe", ulpi_data_oe, 1'b0);
            tick();
            if (!f) exp_rxbyte = b;
            checkFlag("rx_valid", rx_cmd_valid, !f);
            checkOutput("rx_byte", rx_cmd_byte, exp_rxbyte);
        end
        applyIdle();
        tick();
        checkFlag("rx_end_novalid", rx_cmd_valid, 1'b0);
        checkFlag("rx_turnback_busy", ins_busy, 1'b1);
        applyIdle();
        tick();
        checkFlag("rx_busy_off", ins_busy, 1'b0);
    endtask

    task automatic abortOnDir(input logic is_read, input logic in_data, input logic [7:0] addr,
                              input int k, input logic [7:0] first, input int n);
        applyStimulus(1'b1, is_read ? 8'h02 : 8'h01, addr, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        if (in_data && !is_read) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
            tick();
        end
        for (int i = 0; i < k; i++) begin
            applyIdle();
            tick();
            checkFlag("ab_noabort", ins_exec_aborted, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hEE, 1'b0);
        checkFlag("ab_dir_oe", ulpi_data_oe, 1'b0);
        tick();
        checkFlag("ab_aborted", ins_exec_aborted, 1'b1);
        checkFlag("ab_busy", ins_busy, 1'b1);
        rxBurst(first, n);
        checkOutput("ab_phyreg_kept", phyreg_data_out, exp_phyreg);
    endtask

    initial begin
        logic [7:0] instr, addr;
        rst = 1'b1;
        applyIdle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_data", ulpi_data_out, 8'h00);
        checkFlag("rst_oe", ulpi_data_oe, 1'b0);
        checkFlag("rst_stp", ulpi_stp, 1'b0);
        checkFlag("rst_busy", ins_busy, 1'b0);
        checkFlag("rst_done", ins_exec_done, 1'b0);
        checkFlag("rst_aborted", ins_exec_aborted, 1'b0);
        checkOutput("rst_phyreg", phyreg_data_out, 8'h00);
        checkOutput("rst_rxbyte", rx_cmd_byte, 8'h00);
        checkFlag("rst_rxvalid", rx_cmd_valid, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] directed write/read");
        doWrite(8'h0A, 8'h55, 1, 1, 1'b0);
        doRead(8'h16, 8'hA5, 0, 0);

        $display("[TB] dir abort and RX CMD capture");
        abortOnDir(1'b0, 1'b0, 8'h11, 1, 8'h4C, 0);

        $display("[TB] timeouts");
        applyStimulus(1'b1, 8'h02, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            applyIdle();
            tick();
            checkFlag("to_rcmd_aborted", ins_exec_aborted, (i == TIMEOUT));
            checkFlag("to_rcmd_busy", ins_busy, (i != TIMEOUT));
        end
        applyIdle();
        checkFlag("to_rcmd_oe", ulpi_data_oe, 1'b0);
        applyStimulus(1'b1, 8'h02, 8'h06, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            applyIdle();
            tick();
            checkFlag("to_rturn_aborted", ins_exec_aborted, (i == TIMEOUT));
        end
        checkFlag("to_rturn_idle", ins_busy, 1'b0);

        $display("[TB] rejected and ignored execs");
        applyStimulus(1'b1, 8'h01, 8'h40, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkFlag("bad_addr_aborted", ins_exec_aborted, 1'b1);
        checkFlag("bad_addr_busy", ins_busy, 1'b0);
        applyStimulus(1'b1, 8'h07, 8'h03, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0);
        checkFlag("bad_ins_oe", ulpi_data_oe, 1'b0);
        tick();
        checkFlag("bad_ins_aborted", ins_exec_aborted, 1'b1);
        checkOutput("bad_ins_data", ulpi_data_out, 8'h00);
        for (int r = 0; r < 4; r++) begin
            instr = 8'($urandom_range(3, 255));
            addr  = 8'($urandom_range(0, 255));
            if (r[0]) begin
                instr = 8'($urandom_range(1, 2));
                addr  = 8'($urandom_range(64, 255));
            end
            applyStimulus(1'b1, instr, addr, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
            checkFlag("rnd_bad_aborted", ins_exec_aborted, 1'b1);
            checkFlag("rnd_bad_busy", ins_busy, 1'b0);
        end
        applyIdle();
        tick();
        checkFlag("bad_pulse_once", ins_exec_aborted, 1'b0);
        doWrite(8'h2B, 8'hC3, 2, 0, 1'b1);

        $display("[TB] exec while PHY takes the bus");
        applyStimulus(1'b1, 8'h01, 8'h01, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        checkFlag("idle_dir_aborted", ins_exec_aborted, 1'b1);
        rxBurst(8'h1D, 3);

        $display("[TB] instruction reset");
        applyStimulus(1'b1, 8'h01, 8'h08, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        checkFlag("insrst_aborted", ins_exec_aborted, 1'b1);
        checkFlag("insrst_busy", ins_busy, 1'b0);
        checkFlag("insrst_stp", ulpi_stp, 1'b0);
        checkOutput("insrst_data", ulpi_data_out, 8'h00);
        applyStimulus(1'b1, 8'h01, 8'h08, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1);
        checkFlag("insrst_oe", ulpi_data_oe, 1'b0);
        tick();
        checkFlag("insrst_idle_noabort", ins_exec_aborted, 1'b0);
        checkFlag("insrst_idle_busy", ins_busy, 1'b0);

        $display("[TB] randomized transactions");
        for (int r = 0; r < 8; r++) begin
            addr = 8'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: doWrite(addr, 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
                1: doRead(addr, 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
                2: abortOnDir(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
                              $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 4));
                default: begin
                    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
                    tick();
                    checkFlag("rnd_rx_busy", ins_busy, 1'b1);
                    rxBurst(8'($urandom), $urandom_range(0, 5));
                end
            endcase
            checkOutput("rnd_phyreg", phyreg_data_out, exp_phyreg);
            checkOutput("rnd_rxbyte", rx_cmd_byte, exp_rxbyte);
        end

        $display("[TB] async reset mid data phase");
        applyStimulus(1'b1, 8'h01, 8'h21, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        applyIdle();
        checkFlag("arst_pre_oe", ulpi_data_oe, 1'b1);
        #2 rst = 1'b1;
        #1;
        exp_phyreg = 8'h00;
        exp_rxbyte = 8'h00;
        checkFlag("arst_oe", ulpi_data_oe, 1'b0);
        checkFlag("arst_stp", ulpi_stp, 1'b0);
        checkFlag("arst_busy", ins_busy, 1'b0);
        checkOutput("arst_phyreg", phyreg_data_out, exp_phyreg);
        checkOutput("arst_rxbyte", rx_cmd_byte, exp_rxbyte);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkFlag("arst_nodone", ins_exec_done, 1'b0);
            checkFlag("arst_noabort", ins_exec_aborted, 1'b0);
            checkFlag("arst_idle", ins_busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
